sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock, parametrised successor to the dual-clock FIFO, for buffering between pipeline stages within one clock domain.
- Depth is any value ≥ 2, not only a power of 2, and all Depth entries are usable (no sacrificial slot).
- Adds a selectable first-word-fall-through mode, fill level, programmable almost-full/almost-empty flags and synchronous flush.
- Keeps the team's req/valid handshake naming.

Parameters:
Width, 8, bits per word (≥1)
Depth, 8, number of entries (≥2, any integer)
AlmostFullThresh, 6, almost_full_o asserts when level ≥ this (1..Depth)
AlmostEmptyThresh, 1, almost_empty_o asserts when level ≤ this (0..Depth-1)
FallThrough, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous empty request
write_req_i  in  1  push request
write_valid_o  out  1  FIFO can accept a word (level != Depth)
data_i  in  Width  push data
read_req_i  in  1  pop request
read_valid_o  out  1  FIFO holds ≥1 word (level != 0)
data_o  out  Width  read data
level_o  out  $clog2(Depth+1)  current occupancy
almost_full_o  out  1  registered threshold flag
almost_empty_o  out  1  registered threshold flag
err_overflow_o  out  1  sticky push-while-full flag (see Optional Feature)
err_underflow_o  out  1  sticky pop-while-empty flag (see Optional Feature)

Behaviour:
- Reset (rst_ni=0, async):
  - wr_ptr, rd_ptr, level = 0; almost_full_o = 0; almost_empty_o = 1.
  - Registered data_o = 0; error flags = 0.
  - Memory is not reset.
  - read_valid_o = 0, write_valid_o = 1 (both combinational from level).
- Push fires when write_req_i && write_valid_o. Pop fires when read_req_i && read_valid_o. Requests without valid are ignored; no state change.
- Pointers are $clog2(Depth) bits and wrap explicitly: Depth-1 → 0, never by overflow.
- Level update: push only +1; pop only −1; both together unchanged. Simultaneous push+pop is legal at any level where both are valid.
- At level = Depth, a push is refused even with a pop in the same cycle; there is no bypass.
- almost_full_o / almost_empty_o are registered from next-level. They change on the same edge as level_o.
- FallThrough = 0:
  - On pop, data_o ← mem[rd_ptr] on that edge, so data is visible the cycle after the pop.
  - Otherwise data_o holds its value, including across flush.
- FallThrough = 1:
  - data_o = mem[rd_ptr] combinationally while read_valid_o = 1, else 0.
  - A pop advances the pointer, and the next word appears in the same cycle.
  - A word pushed into an empty FIFO is visible the cycle after the push.
- flush_i = 1:
  - On the next edge, pointers and level = 0, almost_full_o = 0, almost_empty_o = 1.
  - Flush has priority: any push or pop in that cycle is discarded; registered data_o is unchanged.
  - Error flags are also cleared by flush.
- Reset asserted mid-operation: immediate return to reset state; contents are lost logically.

Optional Feature:
SYNC_FIFO_ERR_EN
- Defined:
  - err_overflow_o sets when write_req_i=1 while write_valid_o=0.
  - err_underflow_o sets when read_req_i=1 while read_valid_o=0.
  - Both are sticky until reset or flush_i.
- Undefined: both ports are tied to 0 and no flag registers are built.

Decomposition:
- fifo_pkg: function level_width(depth) = $clog2(depth+1) and a parametrised wrap-increment function.
- Elaboration checks: Depth ≥ 2 and the threshold ranges; use $error like other blocks.
- Reuse utils_pkg for common helpers.
- One sub-module: fifo_wrap_counter (Depth, en_i, clr_i, count_o), a modulo-Depth pointer with async reset, instantiated twice.

Test Plan:
- Depth=5, FallThrough=0: push 5 words 0xA0..0xA4.
  - write_valid_o falls after the 5th push; level_o = 5; almost_full_o = 1.
  - A 6th push is ignored.
- Same FIFO: pop 5 times.
  - data_o = 0xA0..0xA4, each the cycle after its pop.
  - read_valid_o = 0 after the last pop; almost_empty_o = 1.
- Depth=5: push+pop every cycle for 23 cycles at level 2.
  - level_o stays 2; in-order data proves the 4→0 wrap.
- FallThrough=1: push 0x3C into an empty FIFO.
  - The next cycle has read_valid_o = 1 and data_o = 0x3C without a pop.
  - A pop with no push returns data_o = 0 and read_valid_o = 0.
- Level 3 with push+pop+flush_i in the same cycle: next cycle level_o = 0, read_valid_o = 0, registered data_o unchanged.
- SYNC_FIFO_ERR_EN defined: pop while empty sets err_underflow_o = 1; it holds until flush_i, then reads 0.
  - Without the macro, the same stimulus keeps it at 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the single-clock FIFO.
//   level_width(depth) : bits needed to hold an occupancy of 0..depth
//   wrap_inc(v, depth) : modulo-depth increment, wraps depth-1 -> 0 explicitly
package fifo_pkg;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointers are compared against depth-1 rather than relying on binary
  // overflow, so non-power-of-two depths use every slot.
  function automatic logic [31:0] wrap_inc(input logic [31:0] value, input int depth);
    return (value == 32'(depth - 1)) ? 32'd0 : value + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wrap_counter.sv
// fifo_wrap_counter: modulo-Depth pointer.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears count to 0
//   en_i    : advance by one (wraps Depth-1 -> 0)
//   clr_i   : synchronous clear, wins over en_i
//   count_o : current pointer value
module fifo_wrap_counter
  import fifo_pkg::*;
#(
  parameter int Depth = 8,
  localparam int PW   = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [PW-1:0] count_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    count_o <= '0;
    else if (clr_i) count_o <= '0;
    else if (en_i)  count_o <= PW'(wrap_inc(32'(count_o), Depth));
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, any Depth >= 2, all entries usable.
// Optional build macro: SYNC_FIFO_ERR_EN builds sticky overflow/underflow
// flags; without it err_overflow_o/err_underflow_o are tied to 0.
// Ports:
//   clk_i, rst_ni            : clock (rising edge), async active-low reset
//   flush_i                  : synchronous empty; overrides push/pop that cycle
//   write_req_i, data_i      : push request and data
//   write_valid_o            : room for a word (level != Depth)
//   read_req_i               : pop request
//   read_valid_o             : holds at least one word (level != 0)
//   data_o                   : read data (registered or fall-through)
//   level_o                  : occupancy 0..Depth
//   almost_full_o/empty_o    : registered level >= / <= threshold flags
//   err_overflow_o/underflow_o : sticky request-while-not-valid flags
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int Width             = 8,
  parameter int Depth             = 8,
  parameter int AlmostFullThresh  = 6,
  parameter int AlmostEmptyThresh = 1,
  parameter bit FallThrough       = 1'b0,
  localparam int LW               = level_width(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             write_req_i,
  output logic             write_valid_o,
  input  logic [Width-1:0] data_i,
  input  logic             read_req_i,
  output logic             read_valid_o,
  output logic [Width-1:0] data_o,
  output logic [LW-1:0]    level_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             err_overflow_o,
  output logic             err_underflow_o
);

  localparam int PW = $clog2(Depth);

  if (Depth < 2) begin : g_chk_depth
    $error("sync_fifo: Depth must be >= 2");
  end
  if (AlmostFullThresh < 1 || AlmostFullThresh > Depth) begin : g_chk_af
    $error("sync_fifo: AlmostFullThresh must be in 1..Depth");
  end
  if (AlmostEmptyThresh < 0 || AlmostEmptyThresh > Depth - 1) begin : g_chk_ae
    $error("sync_fifo: AlmostEmptyThresh must be in 0..Depth-1");
  end

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop;

  assign write_valid_o = (level_q != LW'(Depth));
  assign read_valid_o  = (level_q != '0);
  assign level_o       = level_q;

  // Flush discards any handshake in the same cycle. A full FIFO refuses a
  // push even when a pop fires alongside it (no bypass).
  assign push = write_req_i & write_valid_o & ~flush_i;
  assign pop  = read_req_i  & read_valid_o  & ~flush_i;

  fifo_wrap_counter #(.Depth(Depth)) u_wr_ptr (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(push), .clr_i(flush_i), .count_o(wr_ptr)
  );
  fifo_wrap_counter #(.Depth(Depth)) u_rd_ptr (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(pop), .clr_i(flush_i), .count_o(rd_ptr)
  );

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_comb begin
    level_d = level_q;
    if (flush_i)           level_d = '0;
    else if (push && !pop) level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  // Flags track next-level so they move on the same edge as level_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q        <= '0;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
    end else begin
      level_q        <= level_d;
      almost_full_o  <= (level_d >= LW'(AlmostFullThresh));
      almost_empty_o <= (level_d <= LW'(AlmostEmptyThresh));
    end
  end

  if (FallThrough) begin : g_fwft
    assign data_o = read_valid_o ? mem[rd_ptr] : '0;
  end else begin : g_reg
    logic [Width-1:0] data_q;
    // Holds across flush; only a pop loads it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)  data_q <= '0;
      else if (pop) data_q <= mem[rd_ptr];
    end
    assign data_o = data_q;
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_overflow_o  <= 1'b0;
      err_underflow_o <= 1'b0;
    end else if (flush_i) begin
      err_overflow_o  <= 1'b0;
      err_underflow_o <= 1'b0;
    end else begin
      if (write_req_i && !write_valid_o) err_overflow_o  <= 1'b1;
      if (read_req_i  && !read_valid_o)  err_underflow_o <= 1'b1;
    end
  end
`else
  assign err_overflow_o  = 1'b0;
  assign err_underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: two Depth=5 FIFOs (registered and fall-through) driven by the
// same stimulus and checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int DEPTH = 5;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0, wreq = 1'b0, rreq = 1'b0;
  logic [7:0] din = '0;

  logic       wv0, rv0, af0, ae0, eo0, eu0;
  logic       wv1, rv1, af1, ae1, eo1, eu1;
  logic [7:0] do0, do1;
  logic [2:0] lv0, lv1;

  always #5 clk = ~clk;

  sync_fifo #(.Width(8), .Depth(DEPTH), .AlmostFullThresh(4), .AlmostEmptyThresh(1),
              .FallThrough(1'b0)) u_reg (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .write_req_i(wreq), .write_valid_o(wv0),
    .data_i(din), .read_req_i(rreq), .read_valid_o(rv0), .data_o(do0), .level_o(lv0),
    .almost_full_o(af0), .almost_empty_o(ae0), .err_overflow_o(eo0), .err_underflow_o(eu0)
  );

  sync_fifo #(.Width(8), .Depth(DEPTH), .AlmostFullThresh(4), .AlmostEmptyThresh(1),
              .FallThrough(1'b1)) u_fwft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .write_req_i(wreq), .write_valid_o(wv1),
    .data_i(din), .read_req_i(rreq), .read_valid_o(rv1), .data_o(do1), .level_o(lv1),
    .almost_full_o(af1), .almost_empty_o(ae1), .err_overflow_o(eo1), .err_underflow_o(eu1)
  );

  // Reference model
  logic [7:0] q[$];
  logic [7:0] m_dreg = '0;
  bit         m_ov = 0, m_un = 0;
  int         n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int lvl = q.size();
    logic [7:0] fw = (lvl != 0) ? q[0] : 8'h00;
    chk({tag, ":level0"}, 32'(lv0), 32'(lvl));
    chk({tag, ":level1"}, 32'(lv1), 32'(lvl));
    chk({tag, ":rvalid"}, {30'd0, rv1, rv0}, {30'd0, {2{lvl != 0}}});
    chk({tag, ":wvalid"}, {30'd0, wv1, wv0}, {30'd0, {2{lvl != DEPTH}}});
    chk({tag, ":afull"},  {30'd0, af1, af0}, {30'd0, {2{lvl >= 4}}});
    chk({tag, ":aempty"}, {30'd0, ae1, ae0}, {30'd0, {2{lvl <= 1}}});
    chk({tag, ":data_reg"},  32'(do0), 32'(m_dreg));
    chk({tag, ":data_fwft"}, 32'(do1), 32'(fw));
    chk({tag, ":err_ov"}, {30'd0, eo1, eo0}, {30'd0, {2{ErrEn & m_ov}}});
    chk({tag, ":err_un"}, {30'd0, eu1, eu0}, {30'd0, {2{ErrEn & m_un}}});
  endtask

  // One clock: drive, take the edge, advance the model, compare.
  task automatic step(input string tag, input bit w, input bit r, input bit f,
                      input logic [7:0] d);
    bit can_w = (q.size() != DEPTH);
    bit can_r = (q.size() != 0);
    wreq = w; rreq = r; flush = f; din = d;
    @(posedge clk); #1;
    if (f) begin
      q.delete(); m_ov = 0; m_un = 0;
    end else begin
      if (w && !can_w) m_ov = 1;
      if (r && !can_r) m_un = 1;
      if (r && can_r) m_dreg = q.pop_front();
      if (w && can_w) q.push_back(d);
    end
    wreq = 0; rreq = 0; flush = 0;
    check_all(tag);
  endtask

  initial begin
    #12;
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;

    // Fill to Depth, then a refused 6th push (also a refused push+pop at full).
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 8'hA0 + 8'(i));
    step("push_full", 1, 0, 0, 8'hEE);
    step("pushpop_full", 1, 1, 0, 8'hEF);
    step("pop_after_full", 0, 1, 0, 8'h00);
    step("refill", 1, 0, 0, 8'hB0);
    step("refill", 1, 0, 0, 8'hB1);
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 0, 8'h00);
    step("pop_empty", 0, 1, 0, 8'h00);
    step("hold_err", 0, 0, 0, 8'h00);
    step("flush_err", 0, 0, 1, 8'h00);

    // Streaming at level 2 across many pointer wraps.
    step("lvl2", 1, 0, 0, 8'h10);
    step("lvl2", 1, 0, 0, 8'h11);
    for (int i = 0; i < 23; i++) step("stream", 1, 1, 0, 8'h12 + 8'(i));
    while (q.size() != 0) step("stream_drain", 0, 1, 0, 8'h00);

    // Fall-through into empty, then pop it back out.
    step("fwft_push", 1, 0, 0, 8'h3C);
    step("fwft_pop", 0, 1, 0, 8'h00);

    // Flush beats a simultaneous push+pop at level 3.
    for (int i = 0; i < 3; i++) step("pre_flush", 1, 0, 0, 8'h50 + 8'(i));
    step("flush_pp", 1, 1, 1, 8'h77);

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0), 8'($urandom));

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 0, 8'h60 + 8'(i));
    step("pre_rst_pop", 0, 1, 0, 8'h00);
    #2 rst_n = 1'b0; #1;
    q.delete(); m_dreg = '0; m_ov = 0; m_un = 0;
    check_all("async_rst");
    @(negedge clk); rst_n = 1'b1;
    step("post_rst", 1, 0, 0, 8'h99);
    step("post_rst", 0, 1, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
